// File: rtl/dial_pkg.sv
// Shared constants and types for the dial command front-end.
// The ASCII codes, the issued command layout and the sequencer states.
package dial_pkg;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    localparam int ACC_W = 14;

    typedef struct packed {
        logic [6:0] letter;
        logic [9:0] number;
    } dial_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        NUM,
        SKIP,
        ISSUE,
        GAP,
        DONE
    } seq_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/dial_cmd_sequencer_dec_accum.sv
// Decimal digit accumulator for one rotation line: acc = acc*10 + d per step.
// Also exposes the would-be result of the current step so a final digit can issue directly.
module dec_accum
    import dial_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int NUM_W      = 10,
    localparam int NDIG_W    = $clog2(MAX_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic [3:0]        digit_i,
    output logic [NUM_W-1:0]  value_o,
    output logic [NDIG_W-1:0] ndig_o,
    output logic              bad_o,
    output logic [NUM_W-1:0]  step_value_o,
    output logic              step_bad_o
);

    localparam int PROD_W = ACC_W + 4;
    localparam logic [PROD_W-1:0] LIMIT = PROD_W'((1 << NUM_W) - 1);

    logic [ACC_W-1:0]  acc_q;
    logic [NDIG_W-1:0] ndig_q;
    logic              bad_q;
    logic [PROD_W-1:0] prod;
    logic              full;

    assign full = (ndig_q == NDIG_W'(MAX_DIGITS));
    assign prod = (PROD_W'(acc_q) * PROD_W'(10)) + PROD_W'(digit_i);

    assign step_value_o = prod[NUM_W-1:0];
    assign step_bad_o   = bad_q | full | (prod > LIMIT);

    // Once the digit budget is spent the value is frozen; the line is already bad.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            ndig_q <= '0;
            bad_q  <= 1'b0;
        end else if (clear_i) begin
            acc_q  <= '0;
            ndig_q <= '0;
            bad_q  <= 1'b0;
        end else if (step_i) begin
            bad_q <= step_bad_o;
            if (!full) begin
                acc_q  <= prod[ACC_W-1:0];
                ndig_q <= ndig_q + NDIG_W'(1);
            end
        end
    end

    assign value_o = acc_q[NUM_W-1:0];
    assign ndig_o  = ndig_q;
    assign bad_o   = bad_q;

endmodule

// File: rtl/dial_cmd_sequencer.sv
// Parses an ASCII stream of "L<n>"/"R<n>" lines and issues each as a one-cycle strobe
// with a fixed idle gap, tracking issued/dropped line counts and end-of-stream.
//
// state | meaning
// IDLE  | waiting for a line's first byte (L/R), blank lines ignored
// NUM   | collecting decimal digits until newline
// SKIP  | malformed line, discarding bytes until newline
// ISSUE | strobe cycle for the parsed command
// GAP   | enforced idle cycles between commands
// DONE  | stream finished, sticky until reset
module dial_cmd_sequencer
    import dial_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_DIGITS = 4,
    parameter int NUM_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    output logic [16:0] dial_data,
    output logic        dial_strobe,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count,
    output logic        done
);

    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    seq_state_t        state_q, state_d;
    logic [6:0]        letter_q, letter_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              eos_q, eos_d;

    logic              in_ready_q;
    dial_cmd_t         dial_data_q;
    logic              dial_strobe_q;
    logic [15:0]       cmd_count_q;
    logic [7:0]        err_count_q;
    logic              done_q;

    logic              xfer;
    logic              byte_is_digit;
    logic              acc_clear;
    logic              acc_step;
    logic              err_inc;
    logic              issue;
    logic [NUM_W-1:0]  issue_num;
    dial_cmd_t         issue_cmd;

    logic [NUM_W-1:0]  acc_value;
    logic [NDIG_W-1:0] acc_ndig;
    logic              acc_bad;
    logic [NUM_W-1:0]  step_value;
    logic              step_bad;

    assign xfer          = in_valid & in_ready_q;
    assign byte_is_digit = is_digit(in_byte);

    dec_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .NUM_W      (NUM_W)
    ) u_dec_accum (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (acc_clear),
        .step_i       (acc_step),
        .digit_i      (in_byte[3:0]),
        .value_o      (acc_value),
        .ndig_o       (acc_ndig),
        .bad_o        (acc_bad),
        .step_value_o (step_value),
        .step_bad_o   (step_bad)
    );

    always_comb begin
        state_d   = state_q;
        letter_d  = letter_q;
        gap_d     = gap_q;
        eos_d     = eos_q | (xfer & in_last);
        acc_clear = 1'b0;
        acc_step  = 1'b0;
        err_inc   = 1'b0;
        issue     = 1'b0;
        issue_num = '0;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (in_byte == ASCII_L || in_byte == ASCII_R) begin
                        letter_d  = in_byte[6:0];
                        acc_clear = 1'b1;
                        state_d   = in_last ? DONE : NUM;
                    end else if (in_byte == ASCII_LF || in_byte == ASCII_CR) begin
                        if (in_last) state_d = DONE;
                    end else begin
                        err_inc = 1'b1;
                        state_d = in_last ? DONE : SKIP;
                    end
                end
            end
            NUM: begin
                if (xfer) begin
                    if (byte_is_digit) begin
                        acc_step = 1'b1;
                        // A final digit with no newline closes the line on the spot.
                        if (in_last) begin
                            if (step_bad) begin
                                err_inc = 1'b1;
                                state_d = DONE;
                            end else begin
                                issue     = 1'b1;
                                issue_num = step_value;
                                state_d   = ISSUE;
                            end
                        end
                    end else if (in_byte == ASCII_CR) begin
                        if (in_last) state_d = DONE;
                    end else if (in_byte == ASCII_LF) begin
                        if (acc_ndig == '0 || acc_bad) begin
                            err_inc = 1'b1;
                            state_d = in_last ? DONE : IDLE;
                        end else begin
                            issue     = 1'b1;
                            issue_num = acc_value;
                            state_d   = ISSUE;
                        end
                    end else begin
                        err_inc = 1'b1;
                        state_d = in_last ? DONE : SKIP;
                    end
                end
            end
            SKIP: begin
                if (xfer) begin
                    if (in_last)                  state_d = DONE;
                    else if (in_byte == ASCII_LF) state_d = IDLE;
                end
            end
            ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    state_d = eos_q ? DONE : IDLE;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = eos_q ? DONE : IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        issue_cmd        = '0;
        issue_cmd.letter = letter_q;
        issue_cmd.number = issue_num;
    end

    // Outputs are registered from the next state so the strobe lands in the ISSUE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            letter_q      <= '0;
            gap_q         <= '0;
            eos_q         <= 1'b0;
            in_ready_q    <= 1'b0;
            dial_data_q   <= '0;
            dial_strobe_q <= 1'b0;
            cmd_count_q   <= '0;
            err_count_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            letter_q      <= letter_d;
            gap_q         <= gap_d;
            eos_q         <= eos_d;
            in_ready_q    <= (state_d == IDLE) || (state_d == NUM) || (state_d == SKIP);
            dial_strobe_q <= issue;
            dial_data_q   <= issue ? issue_cmd : '0;
            if (issue && cmd_count_q != 16'hFFFF) cmd_count_q <= cmd_count_q + 16'd1;
            if (err_inc && err_count_q != 8'hFF)  err_count_q <= err_count_q + 8'd1;
            done_q        <= (state_d == DONE);
        end
    end

    assign in_ready    = in_ready_q;
    assign dial_data   = dial_data_q;
    assign dial_strobe = dial_strobe_q;
    assign cmd_count   = cmd_count_q;
    assign err_count   = err_count_q;
    assign done        = done_q;

endmodule

// File: doc/dial_cmd_sequencer.md
Name: dial_cmd_sequencer

Overview:
- Front-end controller for the dial rotation datapath.
- Accepts a raw ASCII byte stream of rotation lines ("L68", "R5", ...) over a valid/ready handshake and parses each line into a packed {letter[6:0], number[9:0]} command.
- Issues each command to the datapath as a single-cycle strobe, with a programmable idle gap between commands.
- Reports end-of-input completion plus command and error counts.

Parameters:
- GAP_CYCLES, 2: idle cycles between consecutive issued commands; data bus held at zero during the gap (0 allowed).
- MAX_DIGITS, 4: maximum decimal digits per line; more digits makes the line an error.
- NUM_W, 10: number field width; values above 2**NUM_W-1 make the line an error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  byte available
- in_byte  in  8  ASCII byte
- in_last  in  1  marks final byte of the stream; qualified by in_valid
- in_ready  out  1  sequencer accepts the byte this cycle
- dial_data  out  17  {letter[6:0], number[9:0]} while dial_strobe=1; all-zero otherwise
- dial_strobe  out  1  one-cycle command-issue pulse
- cmd_count  out  16  commands issued; saturates at 16'hFFFF
- err_count  out  8  lines dropped as malformed; saturates at 8'hFF
- done  out  1  stream finished and last command drained; sticky until reset

Behaviour:
- Reset (reset=0, async): state=IDLE, in_ready=0, dial_data=0, dial_strobe=0, cmd_count=0, err_count=0, done=0, accumulators cleared. in_ready rises on the first clk edge after reset deasserts.
- Byte transfer: a byte transfers only when in_valid && in_ready. All outputs are registered.
- IDLE (in_ready=1):
  - 'L'(8'h4C) or 'R'(8'h52): latch in_byte[6:0] as the letter; acc=0; ndig=0; go to NUM.
  - '\n' or '\r': ignored (blank line).
  - Any other byte: err_count++; go to SKIP.
- NUM (in_ready=1):
  - Digit '0'-'9': acc=acc*10+d, using a 14-bit accumulator.
  - Line is flagged bad if ndig would exceed MAX_DIGITS or acc exceeds 1023.
  - '\r': ignored.
  - '\n' terminates the line. If ndig==0 or the line is flagged bad: err_count++, no issue, go to IDLE. Otherwise go to ISSUE.
  - Any other byte: err_count++; go to SKIP.
- SKIP (in_ready=1): discard bytes until '\n', then go to IDLE.
- ISSUE (in_ready=0): exactly one cycle with dial_strobe=1, dial_data={letter, acc[9:0]}; cmd_count++. Next state is GAP if GAP_CYCLES>0, else IDLE, or DONE if end-of-stream is pending.
- GAP (in_ready=0): down-counter of GAP_CYCLES cycles, then IDLE, or DONE if end-of-stream is pending.
- Latency: '\n' accepted at edge N gives dial_strobe high in cycle N+1; in_ready high again in cycle N+2+GAP_CYCLES.
- in_last handling:
  - Sets the end-of-stream pending flag whenever its byte transfers.
  - If the last byte is a digit in NUM (no trailing newline), the line is terminated as if followed by '\n'.
  - If no command results from the last byte (IDLE blank, SKIP, error), go to DONE on the next edge.
- DONE: in_ready=0, done=1; held until reset. Bytes are never accepted.
- Counter saturation: counters saturate and do not wrap. An error increment and an issue cannot occur in the same cycle.
- Reset mid-line or mid-gap: the partial command is discarded; no strobe is emitted after reset.

Decomposition:
- Shared package dial_pkg holds:
  - ASCII constants: ASCII_L, ASCII_R, ASCII_LF, ASCII_CR, ASCII_0, ASCII_9.
  - typedef dial_cmd_t: packed struct {logic [6:0] letter; logic [9:0] number;}, 17 bits.
  - typedef seq_state_t: enum {IDLE, NUM, SKIP, ISSUE, GAP, DONE}.
- Sub-module dec_accum owns the digit accumulator: clear/step inputs; outputs value, ndig and bad flag.
- The FSM, gap counter and stat counters live in the top module.

Test Plan:
- "L68\n", GAP_CYCLES=2: one strobe 1 cycle after '\n' with dial_data=17'h13044 ({7'h4C, 10'd68}); in_ready low 3 cycles; cmd_count=1.
- "R1023\n" followed by "R1024\n": first is issued with number=1023; second is dropped; err_count=1, cmd_count=1.
- "X12\n" then "L12345\n" then "L\n" then "R5\n": err_count=3; only R5 is issued (dial_data={7'h52, 10'd5}).
- "L3\r\n\n\nR7" with in_last on '7': two strobes (3 then 7); done=1 two gap cycles after the second strobe; in_ready stays 0 afterwards.
- Random in_valid gaps (50% duty) over a 4000-line stream: strobe count equals the golden count of valid lines; dial_data=0 on every non-strobe cycle; strobes never closer than GAP_CYCLES+1 cycles apart.
- Assert reset while in NUM after "R4": all outputs go to 0 immediately; no strobe; after release, "L1\n" issues {7'h4C, 10'd1}.
